// File: rtl/kv10_console_pkg.sv
// ============================================================================
// kv10_console_pkg
// Shared key indices, FSM/command encodings and helpers for the console
// sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package kv10_console_pkg;

  localparam int NUM_KEYS         = 10;
  localparam int KEY_DEPOSIT_THIS = 9;
  localparam int KEY_DEPOSIT_NEXT = 8;
  localparam int KEY_READ_IN      = 7;
  localparam int KEY_START        = 6;
  localparam int KEY_CONT         = 5;
  localparam int KEY_STOP         = 4;
  localparam int KEY_RESET_SWITCH = 3;
  localparam int KEY_XCT          = 2;
  localparam int KEY_EXAMINE_THIS = 1;
  localparam int KEY_EXAMINE_NEXT = 0;

  typedef logic [18:35] addr_t;
  typedef logic [0:35]  word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    MEM   = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    CMD_NONE      = 4'd0,
    CMD_STOP      = 4'd1,
    CMD_RESET     = 4'd2,
    CMD_START     = 4'd3,
    CMD_CONT      = 4'd4,
    CMD_READ_IN   = 4'd5,
    CMD_XCT       = 4'd6,
    CMD_DEP_THIS  = 4'd7,
    CMD_DEP_NEXT  = 4'd8,
    CMD_EXAM_THIS = 4'd9,
    CMD_EXAM_NEXT = 4'd10
  } cmd_t;

  // Highest-priority pending key wins; all others are dropped.
  function automatic cmd_t arbitrate(input logic [NUM_KEYS-1:0] ev);
    if (ev[KEY_STOP])         return CMD_STOP;
    if (ev[KEY_RESET_SWITCH]) return CMD_RESET;
    if (ev[KEY_START])        return CMD_START;
    if (ev[KEY_CONT])         return CMD_CONT;
    if (ev[KEY_READ_IN])      return CMD_READ_IN;
    if (ev[KEY_XCT])          return CMD_XCT;
    if (ev[KEY_DEPOSIT_THIS]) return CMD_DEP_THIS;
    if (ev[KEY_DEPOSIT_NEXT]) return CMD_DEP_NEXT;
    if (ev[KEY_EXAMINE_THIS]) return CMD_EXAM_THIS;
    if (ev[KEY_EXAMINE_NEXT]) return CMD_EXAM_NEXT;
    return CMD_NONE;
  endfunction

  function automatic logic is_repeatable(input cmd_t c);
    return (c == CMD_START) || (c == CMD_CONT) || (c == CMD_XCT) ||
           (c == CMD_EXAM_NEXT) || (c == CMD_DEP_NEXT);
  endfunction

  function automatic logic [3:0] cmd_key(input cmd_t c);
    case (c)
      CMD_START:     return 4'(KEY_START);
      CMD_CONT:      return 4'(KEY_CONT);
      CMD_XCT:       return 4'(KEY_XCT);
      CMD_DEP_NEXT:  return 4'(KEY_DEPOSIT_NEXT);
      default:       return 4'(KEY_EXAMINE_NEXT);
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// key_debounce
// Single console key: scan-strobe debounce counter, stable level, rise pulse.
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_debounce #(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic scan_strobe,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [3:0] c_last = 4'(DEBOUNCE_SCANS - 1);

  logic [3:0] r_cnt;
  logic       r_level;
  logic       r_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      if (scan_strobe) begin
        // Any sample agreeing with the stable level restarts the run.
        if (raw == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == c_last) begin
          r_cnt   <= '0;
          r_level <= raw;
          r_rise  <= raw;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;

endmodule

`default_nettype wire

// File: rtl/console_sequencer.sv
// ============================================================================
// console_sequencer
// PiDP-10 console key sequencer: debounce, command arbitration, examine/
// deposit memory cycles and CPU control pulses. Optional auto-repeat of
// held keys is built when CONSOLE_REPEAT_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module console_sequencer
  import kv10_console_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int REPT_SCANS     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         scan_strobe,
  input  logic [9:0]   keys_raw,
  input  logic [18:35] addr_switches,
  input  logic [0:35]  data_switches,
  input  logic         rept,
  input  logic         cpu_run,
  output logic         mem_req,
  output logic         mem_write,
  output logic [18:35] mem_addr,
  output logic [0:35]  mem_wdata,
  input  logic         mem_ack,
  input  logic [0:35]  mem_rdata,
  output logic         cpu_start,
  output logic         cpu_cont,
  output logic         cpu_stop,
  output logic         cpu_reset,
  output logic         cpu_xct,
  output logic         cpu_read_in,
  output logic [18:35] console_addr,
  output logic [0:35]  console_data,
  output logic         busy,
  output logic         nxm
);

  localparam int          TW         = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT_CYCLES - 1);

  logic [NUM_KEYS-1:0] w_level;
  logic [NUM_KEYS-1:0] w_rise;
  logic [NUM_KEYS-1:0] w_events;
  cmd_t                w_cmd;
  logic                w_go;

  state_t        r_state;
  logic          r_busy, r_nxm, r_req, r_write;
  addr_t         r_caddr;
  word_t         r_cdata, r_wdata;
  logic [TW-1:0] r_tmo;
  logic          r_start, r_cont, r_stop, r_rst, r_xct, r_rdin;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_deb (
        .clk         (clk),
        .reset       (reset),
        .scan_strobe (scan_strobe),
        .raw         (keys_raw[gi]),
        .level       (w_level[gi]),
        .rise        (w_rise[gi])
      );
    end
  endgenerate

`ifdef CONSOLE_REPEAT_EN
  localparam int            RW          = $clog2(REPT_SCANS + 1);
  localparam logic [RW-1:0] c_rept_last = RW'(REPT_SCANS - 1);

  logic                r_rept_valid;
  logic [3:0]          r_rept_key;
  logic [RW-1:0]       r_rept_cnt;
  logic [NUM_KEYS-1:0] r_rept_ev;
  logic                w_rept_held;

  assign w_rept_held = r_rept_valid && w_level[r_rept_key];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rept_valid <= 1'b0;
      r_rept_key   <= '0;
      r_rept_cnt   <= '0;
      r_rept_ev    <= '0;
    end else begin
      r_rept_ev <= '0;
      if (w_go && is_repeatable(w_cmd)) begin
        r_rept_valid <= 1'b1;
        r_rept_key   <= cmd_key(w_cmd);
        r_rept_cnt   <= '0;
      end else if (!rept || !w_rept_held) begin
        r_rept_cnt <= '0;
      end else if (scan_strobe) begin
        if (r_rept_cnt == c_rept_last) begin
          r_rept_cnt            <= '0;
          r_rept_ev[r_rept_key] <= 1'b1;
        end else begin
          r_rept_cnt <= r_rept_cnt + 1'b1;
        end
      end
    end
  end

  assign w_events = w_rise | r_rept_ev;
`else
  logic w_unused_rept;
  assign w_unused_rept = ^{rept, w_level};
  assign w_events      = w_rise;
`endif

  // Stop/reset bypass busy and run gating; everything else needs an idle,
  // halted machine.
  always_comb begin
    w_cmd = arbitrate(w_events);
    w_go  = 1'b0;
    if (w_cmd == CMD_STOP || w_cmd == CMD_RESET)
      w_go = 1'b1;
    else if (w_cmd != CMD_NONE && r_state == IDLE && !cpu_run)
      w_go = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_nxm   <= 1'b0;
      r_req   <= 1'b0;
      r_write <= 1'b0;
      r_caddr <= '0;
      r_cdata <= '0;
      r_wdata <= '0;
      r_tmo   <= '0;
      r_start <= 1'b0;
      r_cont  <= 1'b0;
      r_stop  <= 1'b0;
      r_rst   <= 1'b0;
      r_xct   <= 1'b0;
      r_rdin  <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_cont  <= 1'b0;
      r_stop  <= 1'b0;
      r_rst   <= 1'b0;
      r_xct   <= 1'b0;
      r_rdin  <= 1'b0;
      if (w_go && (w_cmd == CMD_STOP || w_cmd == CMD_RESET)) begin
        r_stop <= (w_cmd == CMD_STOP);
        r_rst  <= (w_cmd == CMD_RESET);
        r_req  <= 1'b0;
        // An aborted memory cycle leaves the sequencer free immediately.
        if (r_state == MEM) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end else begin
          r_state <= PULSE;
          r_busy  <= 1'b1;
        end
      end else begin
        case (r_state)
          IDLE: begin
            if (w_go) begin
              case (w_cmd)
                CMD_START:   begin r_start <= 1'b1; r_state <= PULSE; r_busy <= 1'b1; end
                CMD_CONT:    begin r_cont  <= 1'b1; r_state <= PULSE; r_busy <= 1'b1; end
                CMD_READ_IN: begin r_rdin  <= 1'b1; r_state <= PULSE; r_busy <= 1'b1; end
                CMD_XCT:     begin r_xct   <= 1'b1; r_state <= PULSE; r_busy <= 1'b1; end
                CMD_EXAM_THIS, CMD_EXAM_NEXT, CMD_DEP_THIS, CMD_DEP_NEXT: begin
                  r_state <= MEM;
                  r_busy  <= 1'b1;
                  r_req   <= 1'b1;
                  r_tmo   <= '0;
                  r_write <= (w_cmd == CMD_DEP_THIS) || (w_cmd == CMD_DEP_NEXT);
                  if (w_cmd == CMD_EXAM_THIS || w_cmd == CMD_DEP_THIS)
                    r_caddr <= addr_switches;
                  else
                    r_caddr <= r_caddr + 18'd1;
                  if (w_cmd == CMD_DEP_THIS || w_cmd == CMD_DEP_NEXT) begin
                    r_wdata <= data_switches;
                    r_cdata <= data_switches;
                  end
                end
                default: ;
              endcase
            end
          end
          PULSE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          MEM: begin
            if (mem_ack) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_req   <= 1'b0;
              r_nxm   <= 1'b0;
              if (!r_write)
                r_cdata <= mem_rdata;
            end else if (r_tmo == c_tmo_last) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_req   <= 1'b0;
              r_nxm   <= 1'b1;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_req   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mem_req      = r_req;
  assign mem_write    = r_write;
  assign mem_addr     = r_caddr;
  assign mem_wdata    = r_wdata;
  assign console_addr = r_caddr;
  assign console_data = r_cdata;
  assign busy         = r_busy;
  assign nxm          = r_nxm;
  assign cpu_start    = r_start;
  assign cpu_cont     = r_cont;
  assign cpu_stop     = r_stop;
  assign cpu_reset    = r_rst;
  assign cpu_xct      = r_xct;
  assign cpu_read_in  = r_rdin;

endmodule

`default_nettype wire

// File: tb/tb_console_sequencer.sv
// ============================================================================
// tb_console_sequencer
// Directed self-checking bench for console_sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_console_sequencer;
  import kv10_console_pkg::*;

  localparam logic [9:0] K_EXT = 10'(1) << KEY_EXAMINE_THIS;
  localparam logic [9:0] K_EXN = 10'(1) << KEY_EXAMINE_NEXT;
  localparam logic [9:0] K_DPN = 10'(1) << KEY_DEPOSIT_NEXT;
  localparam logic [9:0] K_STP = 10'(1) << KEY_STOP;
  localparam logic [9:0] K_RSW = 10'(1) << KEY_RESET_SWITCH;
  localparam logic [9:0] K_STA = 10'(1) << KEY_START;
  localparam logic [9:0] K_CNT = 10'(1) << KEY_CONT;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         scan_strobe = 1'b0;
  logic [9:0]   keys_raw = '0;
  logic [18:35] addr_switches = '0;
  logic [0:35]  data_switches = '0;
  logic         rept = 1'b0;
  logic         cpu_run = 1'b0;
  logic         mem_ack = 1'b0;
  logic [0:35]  mem_rdata = '0;
  logic         mem_req, mem_write, busy, nxm;
  logic [18:35] mem_addr, console_addr;
  logic [0:35]  mem_wdata, console_data;
  logic         cpu_start, cpu_cont, cpu_stop, cpu_reset, cpu_xct, cpu_read_in;

  int checks = 0;
  int failures = 0;
  int n_req = 0, n_stop = 0, n_start = 0, n_cont = 0;
  int s0, s1;

  always #5 clk = ~clk;

  console_sequencer dut (
    .clk(clk), .reset(reset), .scan_strobe(scan_strobe), .keys_raw(keys_raw),
    .addr_switches(addr_switches), .data_switches(data_switches), .rept(rept),
    .cpu_run(cpu_run), .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .cpu_start(cpu_start), .cpu_cont(cpu_cont), .cpu_stop(cpu_stop),
    .cpu_reset(cpu_reset), .cpu_xct(cpu_xct), .cpu_read_in(cpu_read_in),
    .console_addr(console_addr), .console_data(console_data), .busy(busy), .nxm(nxm)
  );

  // Per-cycle activity counters, sampled on the edge that closes each cycle.
  always @(posedge clk) begin
    if (mem_req)   n_req++;
    if (cpu_stop)  n_stop++;
    if (cpu_start) n_start++;
    if (cpu_cont)  n_cont++;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0o expected %0o", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [9:0] k);
    keys_raw    = k;
    scan_strobe = 1'b1;
    tick();
    scan_strobe = 1'b0;
    tick();
  endtask

  task automatic press(input logic [9:0] k);
    repeat (3) strobe(k);
  endtask

  task automatic release_keys();
    repeat (3) strobe('0);
  endtask

  task automatic ack(input logic [0:35] d);
    mem_rdata = d;
    mem_ack   = 1'b1;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(3);
    reset = 1'b0;
    tick();
    check("rst_req_busy_nxm", 64'({mem_req, busy, nxm}), 64'(0));
    check("rst_caddr", 64'(console_addr), 64'(0));
    check("rst_cdata", 64'(console_data), 64'(0));
    check("rst_pulses", 64'({cpu_start, cpu_cont, cpu_stop, cpu_reset, cpu_xct, cpu_read_in}), 64'(0));

    // Examine this, ack arrives in the sixth request cycle
    addr_switches = 18'o001000;
    s0 = n_req;
    press(K_EXT);
    check("ex_req", 64'({mem_req, busy}), 64'(3));
    check("ex_write", 64'(mem_write), 64'(0));
    check("ex_addr", 64'(mem_addr), 64'(18'o001000));
    tick(4);
    check("ex_req_held", 64'(mem_req), 64'(1));
    tick();
    ack(36'o123456654321);
    check("ex_done", 64'({mem_req, busy, nxm}), 64'(0));
    check("ex_cdata", 64'(console_data), 64'(36'o123456654321));
    check("ex_req_cycles", 64'(n_req - s0), 64'(6));
    release_keys();

    // Address wrap on examine next
    addr_switches = 18'o777777;
    press(K_EXT);
    ack(36'o0);
    check("wrap_base", 64'(console_addr), 64'(18'o777777));
    release_keys();
    press(K_EXN);
    check("wrap_addr", 64'(mem_addr), 64'(0));
    check("wrap_req", 64'({mem_req, mem_write}), 64'(2));
    ack(36'o5);
    check("wrap_cdata", 64'(console_data), 64'(5));
    release_keys();

    // Deposit next; read data on the ack must not land in console_data
    data_switches = 36'o777000000777;
    press(K_DPN);
    check("dep_write", 64'({mem_req, mem_write}), 64'(3));
    check("dep_wdata", 64'(mem_wdata), 64'(36'o777000000777));
    check("dep_addr", 64'(mem_addr), 64'(1));
    ack(36'o0);
    check("dep_cdata", 64'(console_data), 64'(36'o777000000777));
    release_keys();

    // Timeout with no ack
    addr_switches = 18'o000100;
    s0 = n_req;
    press(K_EXT);
    for (int i = 0; i < 1100 && mem_req; i++) tick();
    check("tmo_req", 64'({mem_req, busy}), 64'(0));
    check("tmo_cycles", 64'(n_req - s0), 64'(1024));
    check("tmo_nxm", 64'(nxm), 64'(1));
    check("tmo_cdata", 64'(console_data), 64'(36'o777000000777));
    release_keys();
    press(K_EXN);
    check("nxm_clr_addr", 64'(mem_addr), 64'(18'o000101));
    ack(36'o1);
    check("nxm_clr", 64'(nxm), 64'(0));
    release_keys();

    // Stop beats examine in the same cycle
    s0 = n_stop;
    s1 = n_req;
    press(K_STP | K_EXT);
    check("stp_pulse", 64'({cpu_stop, mem_req, busy}), 64'(5));
    tick();
    check("stp_end", 64'({cpu_stop, busy}), 64'(0));
    tick();
    check("stp_width", 64'(n_stop - s0), 64'(1));
    check("stp_no_mem", 64'(n_req - s1), 64'(0));
    release_keys();

    // Start discarded while a memory cycle is pending; stop aborts it
    press(K_EXT);
    s0 = n_start;
    press(K_STA);
    tick(2);
    check("busy_start", 64'(n_start - s0), 64'(0));
    check("busy_req", 64'(mem_req), 64'(1));
    press(K_STP);
    check("abort", 64'({cpu_stop, mem_req, busy, nxm}), 64'(8));
    release_keys();

    // Running CPU: reset switch accepted, start discarded
    cpu_run = 1'b1;
    press(K_RSW);
    check("run_reset", 64'(cpu_reset), 64'(1));
    release_keys();
    s0 = n_start;
    press(K_STA);
    tick(2);
    check("run_start", 64'(n_start - s0), 64'(0));
    release_keys();
    cpu_run = 1'b0;

    // Bounce 1,0,1,1,1 gives a single event after the last sample
    s0 = n_cont;
    strobe(K_CNT);
    strobe('0);
    strobe(K_CNT);
    strobe(K_CNT);
    tick(2);
    check("bounce_early", 64'(n_cont - s0), 64'(0));
    strobe(K_CNT);
    tick(2);
    check("bounce_one", 64'(n_cont - s0), 64'(1));
    rept = 1'b1;
    repeat (16) strobe(K_CNT);
    tick(3);
`ifdef CONSOLE_REPEAT_EN
    check("rept_pulses", 64'(n_cont - s0), 64'(3));
`else
    check("rept_ignored", 64'(n_cont - s0), 64'(1));
`endif
    rept = 1'b0;
    release_keys();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
